mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It owns the HI/LO registers, launches mult/multu/div/divu issued from the E stage, runs a fixed-latency busy countdown, and raises the D-stage stall when a mul_div-class instruction (mfhi, mflo, mthi, mtlo, mult, multu, div, divu) meets a busy or just-launching unit. It sits beside the E-stage ALU. The pipeline's hazard unit ORs its `stall` into the global freeze.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `e_op`  in  3  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `e_a`  in  32  E-stage forwarded rs value.
- `e_b`  in  32  E-stage forwarded rt value.
- `req`  in  1  exception/interrupt flush of the E-stage instruction this cycle.
- `d_md`  in  1  D-stage instruction is mul_div class.
- `busy`  out  1  a mult/div is in progress.
- `start`  out  1  combinational: an E-stage mult/div is accepted this cycle.
- `stall`  out  1  combinational D-stage stall request.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- State: IDLE, RUN. Register `cnt` holds the remaining cycles.
- Reset (async): state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0. The latched operands and op clear to 0.
- `start` = IDLE & !req & e_op∈{1,2,3,4}.
- On `start`:
  - Latch `e_a`, `e_b` and the op.
  - Go to RUN with `cnt`=MULT_CYCLES or DIV_CYCLES.
- RUN, each cycle:
  - `cnt` decrements.
  - When `cnt`==1 at an edge, write the result into HI/LO and go to IDLE.
- Results:
  - mult: signed 64-bit product of the latched operands; HI=[63:32], LO=[31:0].
  - multu: unsigned 64-bit product of the latched operands; HI=[63:32], LO=[31:0].
  - div: signed; LO=quotient, HI=remainder. Truncation is toward zero, and the remainder takes the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divisor 0: HI and LO stay unchanged. The full DIV_CYCLES busy period still elapses.
  - div 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- mthi/mtlo:
  - Write `hi`/`lo` from `e_a` at the next edge, only when IDLE & !req.
  - While RUN they are ignored. The stall prevents this case in normal flow.
- An E-stage op other than 0 while RUN is ignored, with no state change.
- `req` while RUN does not cancel. The in-flight operation belongs to an already committed instruction.
- `req` suppresses only the launch or HI/LO write of the current E-stage op.
- `stall` = d_md & (busy | start).

## Timing
- `start` is asserted for 1 cycle, at edge t.
- `busy` is high from after edge t through edge t+N, where N is the configured cycle count. That is exactly N cycles.
- `hi`/`lo` take the result at edge t+N. `busy` falls at the same edge, so mfhi in D sees the new value in the first un-stalled cycle.
- A back-to-back start is legal at edge t+N+1: `start` may assert in the first cycle after `busy` falls.
- mthi/mtlo latency is 1 edge. An mfhi directly following in D then reads through the normal HI/LO output.
- `stall` has no registered delay. It is asserted in the same cycle as `start` when `d_md` is high.
- Reset asserted mid-RUN aborts immediately. HI/LO return to 0 and there is no late write-back.

## Test plan
- Reset, then mult with e_a=32'hFFFFFFFE (−2), e_b=3 → `busy` high for exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
- multu with e_a=32'hFFFFFFFF, e_b=2 → after 5 cycles hi=1, lo=32'hFFFFFFFE.
- div with e_a=−7, e_b=2 → after 10 cycles lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - With d_md held high throughout, `stall`=1 from the start cycle through the last busy cycle, then 0.
- Division by zero:
  - Setup: mthi e_a=32'h1234 followed by mtlo e_a=32'h5678.
  - Stimulus: divu with e_b=0.
  - Required: `busy` high for 10 cycles; afterwards hi=32'h1234, lo=32'h5678.
- `req`=1 in the same cycle as an E-stage mult → start=0, busy=0, hi/lo unchanged.
  - `req`=1 during cycle 3 of a running div → the div completes normally.
- Reset pulse in cycle 4 of a mult (after hi/lo were set nonzero) → busy=0, hi=0, lo=0 immediately.
  - A new mult issued afterwards completes in 5 cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide unit controller: owns HI/LO, runs a fixed-latency busy
// countdown for mult/div and raises the D-stage stall for mul_div-class instructions.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        req,
    input  logic        d_md,
    output logic        busy,
    output logic        start,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // 64-bit product; the signed form sign-extends before an unsigned multiply
    // since only the low 64 bits of the wide product are kept.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = sgn ? {{32{a[31]}}, a} : {32'h0000_0000, a};
        bx = sgn ? {{32{b[31]}}, b} : {32'h0000_0000, b};
        return ax * bx;
    endfunction

    // Returns {remainder, quotient}; signed division goes through magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        mag_a = neg_a ? (~a + 32'd1) : a;
        mag_b = neg_b ? (~b + 32'd1) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        q = (neg_a ^ neg_b) ? (~q + 32'd1) : q;
        r = neg_a ? (~r + 32'd1) : r;
        return {r, q};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic [63:0]      res_s;
    logic             wb_ok_s;
    logic             start_s;

    assign start_s = (state_q == ST_IDLE) && !req && (e_op >= OP_MULT) && (e_op <= OP_DIVU);
    assign start   = start_s;
    assign busy    = (state_q == ST_RUN);
    assign stall   = d_md && ((state_q == ST_RUN) || start_s);
    assign hi      = hi_q;
    assign lo      = lo_q;

    // Result of the latched operation, plus whether it may be written (divide by zero may not).
    always_comb begin
        res_s   = {hi_q, lo_q};
        wb_ok_s = 1'b1;
        case (op_q)
            OP_MULT:  res_s = mul64(a_q, b_q, 1'b1);
            OP_MULTU: res_s = mul64(a_q, b_q, 1'b0);
            OP_DIV: begin
                res_s   = div64(a_q, b_q, 1'b1);
                wb_ok_s = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_s   = div64(a_q, b_q, 1'b0);
                wb_ok_s = (b_q != 32'd0);
            end
            default: begin
                res_s   = {hi_q, lo_q};
                wb_ok_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: launch, countdown, write-back and moves to HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_RUN;
                    op_d    = e_op;
                    a_d     = e_a;
                    b_d     = e_b;
                    cnt_d   = (e_op <= OP_MULTU) ? MULT_CNT : DIV_CNT;
                end else if (!req && (e_op == OP_MTHI)) begin
                    hi_d = e_a;
                end else if (!req && (e_op == OP_MTLO)) begin
                    lo_d = e_a;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // E-stage ops and req are deliberately not looked at while running.
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    hi_d    = wb_ok_s ? res_s[63:32] : hi_q;
                    lo_d    = wb_ok_s ? res_s[31:0]  : lo_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers; reset aborts any in-flight operation with no write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases from the test plan plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  e_op  = 3'd0;
    logic [31:0] e_a   = 32'd0;
    logic [31:0] e_b   = 32'd0;
    logic        req   = 1'b0;
    logic        d_md  = 1'b0;
    logic        busy;
    logic        start;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    // Model: remaining busy cycles, architectural HI/LO and the pending result.
    int          m_left = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi   = 32'd0;
    logic [31:0] p_lo   = 32'd0;
    logic        p_wr   = 1'b0;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .e_op(e_op), .e_a(e_a), .e_b(e_b),
        .req(req), .d_md(d_md), .busy(busy), .start(start), .stall(stall),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {write_enable, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] up;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin sp = sa * sb; up = sp; return {1'b1, up}; end
            3'd2: begin up = ua * ub; return {1'b1, up}; end
            3'd3: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                q = ua / ub;
                r = ua % ub;
                return {1'b1, r[31:0], q[31:0]};
            end
            default: return {1'b0, 64'd0};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            p_wr   <= 1'b0;
        end else if (m_left > 0) begin
            if (m_left == 1 && p_wr) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
            m_left <= m_left - 1;
        end else if (!req) begin
            case (e_op)
                3'd1, 3'd2, 3'd3, 3'd4: begin
                    {p_wr, p_hi, p_lo} <= ref_result(e_op, e_a, e_b);
                    m_left <= (e_op <= 3'd2) ? MC : DC;
                end
                3'd5: m_hi <= e_a;
                3'd6: m_lo <= e_a;
                default: ;
            endcase
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("start", {31'd0, start},
            {31'd0, (m_left == 0) && !req && (e_op >= 3'd1) && (e_op <= 3'd4)});
        chk("stall", {31'd0, stall},
            {31'd0, d_md && ((m_left > 0) || ((m_left == 0) && !req && (e_op >= 3'd1) && (e_op <= 3'd4)))});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input string nm);
        int cnt;
        e_op = op; e_a = a; e_b = b; d_md = dmd;
        @(negedge clk);
        chk({nm, "_start"}, {31'd0, start}, 32'd1);
        if (dmd) chk({nm, "_stall0"}, {31'd0, stall}, 32'd1);
        next_cycle();
        e_op = 3'd0; e_a = $urandom; e_b = $urandom;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk({nm, "_busy_cycles"}, cnt, n);
        chk({nm, "_hi"}, hi, exp_hi);
        chk({nm, "_lo"}, lo, exp_lo);
        if (dmd) chk({nm, "_stall_end"}, {31'd0, stall}, 32'd0);
        next_cycle();
        d_md = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [64:0] r;
        int cnt;
        r = ref_result(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("ref_div_lo", r[31:0], 32'hFFFF_FFFD);
        chk("ref_div_hi", r[63:32], 32'hFFFF_FFFF);
        r = ref_result(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("ref_mult_lo", r[31:0], 32'hFFFF_FFFA);
        r = ref_result(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ref_ovf_lo", r[31:0], 32'h8000_0000);

        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        next_cycle();

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, MC, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DC, 32'd0, 32'h8000_0000, "div_ovf");

        e_op = 3'd5; e_a = 32'h1234;
        next_cycle();
        e_op = 3'd6; e_a = 32'h5678;
        @(negedge clk);
        chk("mthi", hi, 32'h1234);
        next_cycle();
        e_op = 3'd0;
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, DC, 32'h1234, 32'h5678, "divu0");

        e_op = 3'd1; e_a = 32'd5; e_b = 32'd5; req = 1'b1;
        @(negedge clk);
        chk("req_start", {31'd0, start}, 32'd0);
        next_cycle();
        e_op = 3'd0; req = 1'b0;
        @(negedge clk);
        chk("req_busy", {31'd0, busy}, 32'd0);
        chk("req_hi", hi, 32'h1234);
        chk("req_lo", lo, 32'h5678);
        next_cycle();

        // div 100/7 with a flushed mult arriving in its third busy cycle.
        e_op = 3'd3; e_a = 32'd100; e_b = 32'd7;
        next_cycle();
        e_op = 3'd0;
        next_cycle();
        next_cycle();
        req = 1'b1; e_op = 3'd1;
        next_cycle();
        req = 1'b0; e_op = 3'd0;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("div_req_rest", cnt, DC - 3);
        chk("div_req_hi", hi, 32'd2);
        chk("div_req_lo", lo, 32'd14);
        next_cycle();

        // Reset in cycle 4 of a mult.
        e_op = 3'd1; e_a = 32'd3; e_b = 32'd4;
        next_cycle();
        e_op = 3'd0;
        repeat (3) next_cycle();
        reset = 1'b1;
        #1;
        chk("rstrun_busy", {31'd0, busy}, 32'd0);
        chk("rstrun_hi", hi, 32'd0);
        chk("rstrun_lo", lo, 32'd0);
        next_cycle();
        reset = 1'b0;
        run_op(3'd1, 32'd7, 32'hFFFF_FFFA, 1'b0, MC, 32'hFFFF_FFFF, 32'hFFFF_FFD6, "mult_after_rst");

        for (int i = 0; i < 600; i++) begin
            e_op  = 3'($urandom_range(0, 7));
            e_a   = rnd_operand();
            e_b   = rnd_operand();
            req   = ($urandom_range(0, 7) == 0);
            d_md  = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 149) == 0);
            next_cycle();
        end
        reset = 1'b0; e_op = 3'd0; req = 1'b0; d_md = 1'b0;
        repeat (DC + 2) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
